// File: rtl/multadd_pkg.sv
// multadd_pkg: shared widths, default FIFO depth and result-entry layout
package multadd_pkg;
  localparam int W = 10;
  localparam int DEPTH_DEFAULT = 4;
  typedef struct packed {
    logic [W-1:0] y;
    logic         id;
  } res_t;
endpackage

// File: rtl/lab4dpath.sv
// lab4dpath: combinational multiply-add datapath, y = x1*x2 + x3 modulo 2^W
module lab4dpath #(
  parameter int W = 10
) (
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic [W-1:0] y
);
  assign y = x1 * x2 + x3;
endmodule

// File: rtl/multadd_fifo.sv
// multadd_fifo: result queue with push/pop/count; the top never pops when empty or pushes when full
module multadd_fifo
  import multadd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW = W + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          empty
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = r_count == '0;
  // storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wdata;
  end
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= (push && !pop) ? r_count + 1'b1 : (!push && pop) ? r_count - 1'b1 : r_count;
    end
  end
endmodule

// File: rtl/multadd_arb.sv
// multadd_arb: two-requester round-robin front end feeding one multiply-add stage and a result FIFO
module multadd_arb #(
  parameter int DEPTH = multadd_pkg::DEPTH_DEFAULT,
  parameter int W = multadd_pkg::W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_x1,
  input  logic [W-1:0] req0_x2,
  input  logic [W-1:0] req0_x3,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_x1,
  input  logic [W-1:0] req1_x2,
  input  logic [W-1:0] req1_x3,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic         res_id,
  output logic [15:0]  served_cnt
);
  logic         r_s1_valid, r_s1_id, r_last_id;
  logic [W-1:0] r_x1, r_x2, r_x3;
  logic [15:0]  r_served;
  logic         w_any, w_grant, w_can, w_xfer, w_pop, w_empty;
  logic [W-1:0] w_y;
  logic [W:0]   w_head;
  logic [AW:0]  w_count;
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = (req0_valid & req1_valid) ? ~r_last_id : req1_valid;
  // credit counts the stage-1 entry so it always has a FIFO slot; a same-cycle pop is not credited
  assign w_can      = (32'(w_count) + 32'(r_s1_valid)) < DEPTH;
  assign req0_ready = ~reset & w_can & w_any & ~w_grant;
  assign req1_ready = ~reset & w_can & w_any & w_grant;
  assign w_xfer     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign res_valid  = ~w_empty;
  assign w_pop      = res_valid & res_ready;
  assign {res_y, res_id} = res_valid ? w_head : '0;
  assign served_cnt = r_served;
  // stage-1 capture of the granted triple; last_id resets to 1 so req0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_last_id  <= 1'b1;
      r_x1       <= '0;
      r_x2       <= '0;
      r_x3       <= '0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_x1      <= w_grant ? req1_x1 : req0_x1;
        r_x2      <= w_grant ? req1_x2 : req0_x2;
        r_x3      <= w_grant ? req1_x3 : req0_x3;
        r_s1_id   <= w_grant;
        r_last_id <= w_grant;
      end
    end
  end
  // popped-result counter, wraps at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_served <= '0;
    else if (w_pop) r_served <= r_served + 16'd1;
  end
  lab4dpath #(.W(W)) u_dp (
    .x1(r_x1),
    .x2(r_x2),
    .x3(r_x3),
    .y (w_y)
  );
  multadd_fifo #(.DEPTH(DEPTH), .DW(W + 1)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (r_s1_valid),
    .pop  (w_pop),
    .wdata({w_y, r_s1_id}),
    .rdata(w_head),
    .count(w_count),
    .empty(w_empty)
  );
endmodule

// File: tb/tb_multadd_arb.sv
// tb_multadd_arb: directed scenarios with a scoreboard of golden multiply-add results
module tb_multadd_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
  logic        req0_ready, req1_ready, res_valid, res_id;
  logic [9:0]  req0_x1 = '0, req0_x2 = '0, req0_x3 = '0;
  logic [9:0]  req1_x1 = '0, req1_x2 = '0, req1_x3 = '0;
  logic [9:0]  res_y;
  logic [15:0] served_cnt;
  int n_cmp = 0, n_bad = 0, n_acc = 0, base;
  multadd_pkg::res_t q[$];
  multadd_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_x3(req0_x3),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_x3(req1_x3),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_id(res_id), .served_cnt(served_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] gold(input int a, input int b, input int c);
    int t;
    t = a * b + c;
    return 10'(t);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    multadd_pkg::res_t e;
    #1;
    if (res_valid && res_ready) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = q.pop_front();
        chk("res_y", res_y, e.y);
        chk("res_id", res_id, e.id);
      end
    end
    if (req0_valid && req0_ready) begin
      e.y = gold(req0_x1, req0_x2, req0_x3); e.id = 1'b0; q.push_back(e); n_acc++;
    end
    if (req1_valid && req1_ready) begin
      e.y = gold(req1_x1, req1_x2, req1_x3); e.id = 1'b1; q.push_back(e); n_acc++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask
  initial begin
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_served", served_cnt, 0);
    reset = 1'b0; req1_valid = 1'b0;
    // single request latency
    req0_x1 = 10'h001; req0_x2 = 10'h002; req0_x3 = 10'h003;
    #1;
    chk("s1_ready0", req0_ready, 1);
    chk("s1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("s1_lat_valid_early", res_valid, 0);
    tick();
    chk("s1_lat_valid", res_valid, 1);
    chk("s1_y", res_y, 10'h005);
    chk("s1_id", res_id, 0);
    tick();
    chk("s1_served", served_cnt, 1);
    // round-robin under continuous contention
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_x1 = 10'(i + 1); req0_x2 = 10'd3; req0_x3 = 10'd7;
      req1_x1 = 10'(i + 10); req1_x2 = 10'd50; req1_x3 = 10'(100 + i);
      #1;
      chk("rr_ready0", req0_ready, (i % 2) == 0);
      chk("rr_ready1", req1_ready, (i % 2) == 1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("rr_drained", q.size(), 0);
    chk("rr_served", served_cnt, 6);
    // backpressure fills exactly DEPTH entries
    res_ready = 1'b0; req1_valid = 1'b1;
    base = n_acc;
    for (int i = 0; i < 8; i++) begin
      req1_x1 = 10'(20 + i); req1_x2 = 10'(33 + i); req1_x3 = 10'(i * 7);
      tick();
    end
    chk("bp_accepted", n_acc - base, 4);
    chk("bp_ready1", req1_ready, 0);
    chk("bp_head_y", res_y, q[0].y);
    tick(); tick();
    chk("bp_head_stable", res_y, q[0].y);
    chk("bp_head_id", res_id, 1);
    res_ready = 1'b1;
    #1;
    chk("bp_pop_no_credit", req1_ready, 0);
    tick();
    res_ready = 1'b0;
    base = n_acc;
    repeat (4) tick();
    chk("bp_one_more", n_acc - base, 1);
    req1_valid = 1'b0; res_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drained", q.size(), 0);
    // simultaneous push and pop at count 2
    res_ready = 1'b0; req0_valid = 1'b1;
    req0_x1 = 10'd100; req0_x2 = 10'd9; req0_x3 = 10'd1;
    tick();
    req0_x1 = 10'd200; req0_x2 = 10'd11; req0_x3 = 10'd2;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("pp_count_pre", dut.u_fifo.count, 2);
    req0_valid = 1'b1; req0_x1 = 10'd300; req0_x2 = 10'd13; req0_x3 = 10'd3;
    tick();
    req0_valid = 1'b0; res_ready = 1'b1;
    tick();
    chk("pp_count_same", dut.u_fifo.count, 2);
    repeat (6) tick();
    chk("pp_drained", q.size(), 0);
    // reset mid-operation discards queued and in-flight results
    res_ready = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_x1 = 10'(40 + i); req0_x2 = 10'd5; req0_x3 = 10'd9;
      tick();
    end
    req0_valid = 1'b0;
    chk("mr_count", dut.u_fifo.count, 3);
    chk("mr_s1_valid", dut.r_s1_valid, 1);
    reset = 1'b1;
    #1;
    chk("mr_res_valid", res_valid, 0);
    chk("mr_served", served_cnt, 0);
    q.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    reset = 1'b0; res_ready = 1'b1;
    #1;
    chk("mr_tie_ready0", req0_ready, 1);
    chk("mr_tie_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("mr_drained", q.size(), 0);
    chk("mr_served_one", served_cnt, 1);
    // served counter wrap
    pulse_reset();
    base = n_acc;
    for (int g = 0; g < 70000 && served_cnt != 16'hFFFF; g++) begin
      req0_valid = (n_acc - base) < 65535;
      req0_x1 = 10'(g); req0_x2 = 10'(g >> 3); req0_x3 = 10'(g * 5);
      tick();
    end
    req0_valid = 1'b0;
    chk("wr_served_max", served_cnt, 16'hFFFF);
    chk("wr_idle", res_valid, 0);
    req0_valid = 1'b1; req0_x1 = 10'd7; req0_x2 = 10'd8; req0_x3 = 10'd9;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("wr_pending", res_valid, 1);
    chk("wr_served_hold", served_cnt, 16'hFFFF);
    tick();
    chk("wr_served_wrap", served_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
